// File: rtl/loader_sink.sv
// Loader-side download endpoint: packs acknowledged loader bytes into 16-bit
// words and commits them to the SDRAM arbiter, flushing any partial word at the end.
module loader_sink #(
  parameter int LDR_AW = 19,
  parameter int MEM_AW = LDR_AW - 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ldr_oe,
  input  logic              ldr_wr,
  input  logic [LDR_AW-1:0] ldr_adr,
  input  logic [7:0]        ldr_wdat,
  input  logic              ldr_done,
  output logic              ldr_ack,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [15:0]       mem_wdat,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_HOLD0,
    S_HOLD1,
    S_WRITE,
    S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic              pend_v;
  logic [MEM_AW-1:0] pend_wadr;
  logic [15:0]       pend_dat;
  logic [1:0]        pend_be;

  logic              wr_req;
  logic [MEM_AW-1:0] adr_word;
  logic              capture;
  logic              commit;

  assign wr_req   = ldr_oe & ldr_wr;
  assign adr_word = ldr_adr[LDR_AW-1:1];

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_v && (ldr_done || !ldr_oe)) begin
          state_d = S_FLUSH;
        end else if (wr_req && pend_v && (adr_word != pend_wadr)) begin
          // the new byte stays unacknowledged and is re-evaluated after the write
          state_d = S_WRITE;
        end else if (wr_req) begin
          capture = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_HOLD0;
      S_HOLD0: state_d = S_HOLD1;
      S_HOLD1: state_d = (pend_be == 2'b11) ? S_WRITE : S_IDLE;
      S_WRITE, S_FLUSH: begin
        if (mem_ack) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_v    <= 1'b0;
      pend_wadr <= '0;
      pend_dat  <= '0;
      pend_be   <= '0;
    end else if (commit) begin
      pend_v   <= 1'b0;
      pend_dat <= '0;
      pend_be  <= '0;
    end else if (capture) begin
      pend_v    <= 1'b1;
      pend_wadr <= adr_word;
      if (ldr_adr[0]) begin
        pend_dat[15:8] <= ldr_wdat;
        pend_be[1]     <= 1'b1;
      end else begin
        pend_dat[7:0]  <= ldr_wdat;
        pend_be[0]     <= 1'b1;
      end
    end
  end

  // outputs come from state and the pending buffer only; busy alone follows ldr_oe
  assign ldr_ack  = (state_q == S_ACK);
  assign mem_req  = (state_q == S_WRITE) || (state_q == S_FLUSH);
  assign mem_adr  = pend_wadr;
  assign mem_wdat = pend_dat;
  assign mem_be   = pend_be;
  assign busy     = ldr_oe | pend_v | (state_q != S_IDLE);

endmodule
